// File: rtl/spi_command_sequencer_pkg.sv
// Shared types and default constants for the SPI command sequencer.
// The command record width follows the existing SPI package-width constant.
package spi_command_sequencer_pkg;

  localparam int SPI_PACKAGE_SIZE   = 8;
  localparam int GAP_CYCLES_DEF     = 3;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } seq_state_e;

  typedef struct packed {
    logic                        rw;
    logic [SPI_PACKAGE_SIZE-2:0] addr;
    logic [SPI_PACKAGE_SIZE-1:0] data;
  } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; pushes while full and pops while empty are ignored.
module spi_cmd_fifo
  import spi_command_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  spi_cmd_t push_cmd,
  input  logic     pop,
  output spi_cmd_t head,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  spi_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

endmodule

// File: rtl/spi_command_sequencer.sv
// Buffers register commands and issues them to the spi driver one at a time.
// Optional watchdog on the wait states: define SPI_SEQ_TIMEOUT_EN.
module spi_command_sequencer
  import spi_command_sequencer_pkg::*;
#(
  parameter int PACKAGE_SIZE   = SPI_PACKAGE_SIZE,
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [PACKAGE_SIZE-2:0] cmd_addr,
  input  logic [PACKAGE_SIZE-1:0] cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PACKAGE_SIZE-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    spi_rw_op,
  output logic [PACKAGE_SIZE-2:0] spi_addr,
  output logic [PACKAGE_SIZE-1:0] spi_data,
  output logic                    spi_send,
  input  logic                    spi_busy,
  input  logic                    spi_data_ready,
  input  logic [PACKAGE_SIZE-1:0] spi_data_out,
  output logic                    idle,
  output logic                    err_timeout,
  input  logic                    err_clear
);
  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  seq_state_e              state_q, state_d;
  spi_cmd_t                push_cmd, head;
  logic                    full, empty, pop, launch_ok, timeout;
  logic                    got_dr;
  logic [GW-1:0]           gap_cnt;
  logic                    rsp_set, rsp_set_err;
  logic [PACKAGE_SIZE-1:0] rsp_set_data;

  assign push_cmd = {cmd_rw, cmd_addr, cmd_data};

  spi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign cmd_ready = !full;
  // Reads block at the head while a response is pending; writes never do.
  assign launch_ok = !empty && (!head.rw || !rsp_valid);
  assign spi_send  = (state_q == ST_LAUNCH);
  assign idle      = empty && (state_q == ST_IDLE) && !rsp_valid;

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    rsp_set      = 1'b0;
    rsp_set_err  = 1'b0;
    rsp_set_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout) begin
          state_d     = ST_GAP;
          rsp_set     = spi_rw_op;
          rsp_set_err = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (spi_rw_op && !got_dr && spi_data_ready) begin
          rsp_set      = 1'b1;
          rsp_set_data = spi_data_out;
        end
        if (!spi_busy) begin
          state_d = ST_GAP;
          if (spi_rw_op && !got_dr && !spi_data_ready) begin
            rsp_set      = 1'b1;
            rsp_set_err  = 1'b1;
            rsp_set_data = spi_data_out;
          end
        end else if (timeout) begin
          state_d = ST_GAP;
          if (spi_rw_op && !got_dr && !spi_data_ready) begin
            rsp_set     = 1'b1;
            rsp_set_err = 1'b1;
          end
        end
      end
      ST_GAP: begin
        // The last gap cycle doubles as the IDLE decision so the next send
        // lands exactly GAP_CYCLES+1 cycles after busy was seen low.
        if (gap_cnt == GAP_LAST) begin
          if (launch_ok) begin
            pop     = 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      spi_rw_op <= 1'b0;
      spi_addr  <= '0;
      spi_data  <= '0;
      gap_cnt   <= '0;
      got_dr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        spi_rw_op <= head.rw;
        spi_addr  <= head.addr;
        spi_data  <= head.data;
      end
      gap_cnt <= (state_q == ST_GAP && state_d == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (state_q == ST_LAUNCH) got_dr <= 1'b0;
      else if (rsp_set)         got_dr <= 1'b1;
      if (rsp_set) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rsp_set_data;
        rsp_err   <= rsp_set_err;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign timeout = waiting && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, so each wait state gets its own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt <= (waiting && state_d == state_q) ? to_cnt + 1'b1 : '0;
      if (timeout)        err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign timeout          = 1'b0;
  assign err_timeout      = 1'b0;
`endif

endmodule
